// File: rtl/tile_game_pkg.sv
// Shared types and constants for the tile rhythm game lanes.
// Used by tile_hit_judge and btn_sync_edge.
package tile_game_pkg;

   localparam int unsigned SCORE_W     = 16;
   localparam int unsigned COUNT_W     = 8;
   localparam int unsigned COMBO_W     = 8;
   localparam int unsigned PTS_W       = 4;
   localparam int unsigned PTS_PERFECT = 3;
   localparam int unsigned PTS_GOOD    = 1;

   typedef enum logic [1:0] {
      GRADE_NONE    = 2'd0,
      GRADE_MISS    = 2'd1,
      GRADE_GOOD    = 2'd2,
      GRADE_PERFECT = 2'd3
   } grade_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } judge_state_t;

   // Final value the lane counter reaches before it stops; stop_at of 0 encodes 256.
   function automatic logic [COUNT_W-1:0] stop_last_f(input logic [COUNT_W-1:0] stop_at);
      return (stop_at == '0) ? {COUNT_W{1'b1}} : COUNT_W'(stop_at - COUNT_W'(1));
   endfunction

endpackage

// File: rtl/tile_hit_judge_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous key plus a registered rising-edge pulse.
// btn_rise is high for one cycle, three clocks after a rise on btn_raw.
module btn_sync_edge
   import tile_game_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic rise_q,  rise_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      rise_d  = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
      end
   end

   assign btn_rise = rise_q;

endmodule

// File: rtl/tile_hit_judge.sv
// Per-lane hit judge: grades one key press per falling tile and keeps a saturating score.
// Optional combo tracking and point doubling: define TILE_HIT_JUDGE_COMBO_EN.
module tile_hit_judge
   import tile_game_pkg::*;
#(
   parameter logic [COUNT_W-1:0] TARGET      = 8'd200,
   parameter logic [COUNT_W-1:0] PERFECT_WIN = 8'd4,
   parameter logic [COUNT_W-1:0] GOOD_WIN    = 8'd12
`ifdef TILE_HIT_JUDGE_COMBO_EN
   ,
   parameter logic [COMBO_W-1:0] COMBO_THRESH = 8'd10
`endif
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               tile_active,
   input  logic [COUNT_W-1:0] count,
   input  logic [COUNT_W-1:0] stop_at,
   input  logic               btn_raw,
   output logic               grade_valid,
   output logic [1:0]         grade,
   output logic [SCORE_W-1:0] score,
   output logic [COMBO_W-1:0] combo
);

   localparam int unsigned DIFF_W = COUNT_W + 1;
   localparam int unsigned SUM_W  = SCORE_W + 1;

   judge_state_t       state_q, state_d;
   grade_t             grade_q, grade_d;
   logic               grade_valid_q, grade_valid_d;
   logic [SCORE_W-1:0] score_q, score_d;

   logic               btn_rise;
   logic [COUNT_W-1:0] stop_last;
   logic [DIFF_W-1:0]  diff;
   grade_t             press_grade;
   logic [PTS_W-1:0]   pts;
   logic [SUM_W-1:0]   sum;

   btn_sync_edge u_btn_sync_edge (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .btn_rise (btn_rise)
   );

   // Distance from the hit line, unsigned and without wrap.
   always_comb begin
      stop_last = stop_last_f(stop_at);
      if (count >= TARGET) diff = {1'b0, count} - {1'b0, TARGET};
      else                 diff = {1'b0, TARGET} - {1'b0, count};
      if (diff <= {1'b0, PERFECT_WIN})   press_grade = GRADE_PERFECT;
      else if (diff <= {1'b0, GOOD_WIN}) press_grade = GRADE_GOOD;
      else                               press_grade = GRADE_MISS;
   end

   // Judge FSM: a press beats expiry in the same cycle; dropping the tile aborts silently.
   always_comb begin
      state_d       = state_q;
      grade_d       = grade_q;
      grade_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tile_active) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!tile_active) begin
               state_d = ST_IDLE;
            end else if (btn_rise) begin
               grade_d       = press_grade;
               grade_valid_d = 1'b1;
               state_d       = ST_DONE;
            end else if (count == stop_last) begin
               grade_d       = GRADE_MISS;
               grade_valid_d = 1'b1;
               state_d       = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!tile_active) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef TILE_HIT_JUDGE_COMBO_EN
   logic [COMBO_W-1:0] combo_q, combo_d;
`endif

   // Points for the grade being registered; score clamps rather than wraps.
   always_comb begin
      score_d = score_q;
      case (grade_d)
         GRADE_PERFECT: pts = PTS_W'(PTS_PERFECT);
         GRADE_GOOD:    pts = PTS_W'(PTS_GOOD);
         default:       pts = '0;
      endcase
`ifdef TILE_HIT_JUDGE_COMBO_EN
      combo_d = combo_q;
      if (combo_q >= COMBO_THRESH) pts = pts << 1;
      if (grade_valid_d) begin
         if (grade_d == GRADE_MISS)         combo_d = '0;
         else if (combo_q != {COMBO_W{1'b1}}) combo_d = combo_q + COMBO_W'(1);
      end
`endif
      sum = {1'b0, score_q} + SUM_W'(pts);
      if (grade_valid_d) score_d = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         grade_q       <= GRADE_NONE;
         grade_valid_q <= 1'b0;
         score_q       <= '0;
`ifdef TILE_HIT_JUDGE_COMBO_EN
         combo_q       <= '0;
`endif
      end else begin
         state_q       <= state_d;
         grade_q       <= grade_d;
         grade_valid_q <= grade_valid_d;
         score_q       <= score_d;
`ifdef TILE_HIT_JUDGE_COMBO_EN
         combo_q       <= combo_d;
`endif
      end
   end

   assign grade_valid = grade_valid_q;
   assign grade       = grade_q;
   assign score       = score_q;
`ifdef TILE_HIT_JUDGE_COMBO_EN
   assign combo       = combo_q;
`else
   assign combo       = '0;
`endif

endmodule

// File: tb/tb_tile_hit_judge.sv
// Directed bench for tile_hit_judge: vector table of single tiles plus hand-built
// sequences for expiry, abort, saturation, mid-tile reset and combo scoring.
module tb_tile_hit_judge;

   logic        clk;
   logic        reset;
   logic        tile_active;
   logic [7:0]  count;
   logic [7:0]  stop_at;
   logic        btn_raw;
   logic        grade_valid;
   logic [1:0]  grade;
   logic [15:0] score;
   logic [7:0]  combo;

   int checks;
   int errors;
   int exp_score;
   int exp_combo;

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_MISS = 2'd1;
   localparam logic [1:0] G_GOOD = 2'd2;
   localparam logic [1:0] G_PERF = 2'd3;

   typedef struct {
      logic [7:0] cnt;
      logic [7:0] stop;
      logic       press;
      logic [1:0] exp_grade;
   } vec_t;

   vec_t vecs[12];

   tile_hit_judge dut (
      .clk         (clk),
      .reset       (reset),
      .tile_active (tile_active),
      .count       (count),
      .stop_at     (stop_at),
      .btn_raw     (btn_raw),
      .grade_valid (grade_valid),
      .grade       (grade),
      .score       (score),
      .combo       (combo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference scoring, written from the grade -> points rules.
   task automatic model_apply(input logic [1:0] g);
      int pts;
      pts = 0;
      if (g == G_PERF) pts = 3;
      else if (g == G_GOOD) pts = 1;
`ifdef TILE_HIT_JUDGE_COMBO_EN
      if (exp_combo >= 10) pts = pts * 2;
      if (g == G_MISS) exp_combo = 0;
      else if (exp_combo < 255) exp_combo = exp_combo + 1;
`endif
      exp_score = exp_score + pts;
      if (exp_score > 65535) exp_score = 65535;
   endtask

   task automatic do_reset();
      tile_active = 1'b0;
      btn_raw     = 1'b0;
      count       = 8'd0;
      stop_at     = 8'd0;
      reset       = 1'b1;
      step();
      step();
      reset       = 1'b0;
      exp_score   = 0;
      exp_combo   = 0;
      step();
   endtask

   // One tile: the press (if any) lands in the first ARMED cycle.
   task automatic run_tile(input int idx, input vec_t v);
      btn_raw     = 1'b0;
      tile_active = 1'b0;
      repeat (4) step();
      count   = v.cnt;
      stop_at = v.stop;
      btn_raw = v.press;
      step();
      step();
      tile_active = 1'b1;
      step();
      step();
      model_apply(v.exp_grade);
      chk($sformatf("vec%0d_valid", idx), int'(grade_valid), 1);
      chk($sformatf("vec%0d_grade", idx), int'(grade), int'(v.exp_grade));
      chk($sformatf("vec%0d_score", idx), int'(score), exp_score);
      chk($sformatf("vec%0d_combo", idx), int'(combo), exp_combo);
      step();
      chk($sformatf("vec%0d_pulse_width", idx), int'(grade_valid), 0);
      btn_raw     = 1'b0;
      tile_active = 1'b0;
   endtask

   // Back-to-back tiles, one grade every three cycles, all at the same count.
   task automatic burst(input int n, input logic [7:0] cnt, input logic [1:0] g);
      count       = cnt;
      stop_at     = 8'd0;
      tile_active = 1'b0;
      btn_raw     = 1'b0;
      repeat (4) step();
      for (int per = 0; per <= n; per++) begin
         tile_active = (per > 0);
         btn_raw     = 1'b0;
         step();
         btn_raw     = (per < n);
         step();
         tile_active = 1'b0;
         btn_raw     = 1'b0;
         step();
      end
      repeat (4) step();
      for (int k = 0; k < n; k++) model_apply(g);
   endtask

   initial begin
      logic seen;
      checks = 0;
      errors = 0;

      vecs[0]  = '{cnt: 8'd202, stop: 8'd0,   press: 1'b1, exp_grade: G_PERF};
      vecs[1]  = '{cnt: 8'd212, stop: 8'd0,   press: 1'b1, exp_grade: G_GOOD};
      vecs[2]  = '{cnt: 8'd213, stop: 8'd0,   press: 1'b1, exp_grade: G_MISS};
      vecs[3]  = '{cnt: 8'd188, stop: 8'd0,   press: 1'b1, exp_grade: G_GOOD};
      vecs[4]  = '{cnt: 8'd187, stop: 8'd0,   press: 1'b1, exp_grade: G_MISS};
      vecs[5]  = '{cnt: 8'd196, stop: 8'd0,   press: 1'b1, exp_grade: G_PERF};
      vecs[6]  = '{cnt: 8'd204, stop: 8'd0,   press: 1'b1, exp_grade: G_PERF};
      vecs[7]  = '{cnt: 8'd205, stop: 8'd0,   press: 1'b1, exp_grade: G_GOOD};
      vecs[8]  = '{cnt: 8'd0,   stop: 8'd0,   press: 1'b1, exp_grade: G_MISS};
      vecs[9]  = '{cnt: 8'd255, stop: 8'd0,   press: 1'b0, exp_grade: G_MISS};
      vecs[10] = '{cnt: 8'd203, stop: 8'd204, press: 1'b1, exp_grade: G_PERF};
      vecs[11] = '{cnt: 8'd10,  stop: 8'd11,  press: 1'b1, exp_grade: G_MISS};

      tile_active = 1'b0;
      btn_raw     = 1'b0;
      count       = 8'd0;
      stop_at     = 8'd0;
      reset       = 1'b1;
      step();
      chk("reset_valid", int'(grade_valid), 0);
      chk("reset_grade", int'(grade), int'(G_NONE));
      chk("reset_score", int'(score), 0);
      chk("reset_combo", int'(combo), 0);
      do_reset();

      for (int i = 0; i < 12; i++) run_tile(i, vecs[i]);

      // Expiry: counter runs to 255 unpressed, later press is ignored.
      repeat (4) step();
      stop_at     = 8'd0;
      count       = 8'd190;
      tile_active = 1'b1;
      seen        = 1'b0;
      for (int c = 190; c < 255; c++) begin
         count = 8'(c);
         step();
         if (grade_valid) seen = 1'b1;
      end
      count = 8'd255;
      step();
      model_apply(G_MISS);
      chk("expire_no_early", int'(seen), 0);
      chk("expire_valid", int'(grade_valid), 1);
      chk("expire_grade", int'(grade), int'(G_MISS));
      chk("expire_score", int'(score), exp_score);
      btn_raw = 1'b1;
      seen    = 1'b0;
      repeat (8) begin
         step();
         if (grade_valid) seen = 1'b1;
      end
      chk("expire_late_press", int'(seen), 0);
      btn_raw     = 1'b0;
      tile_active = 1'b0;

      // Abort: tile dropped while armed gives nothing.
      repeat (4) step();
      count       = 8'd100;
      tile_active = 1'b1;
      repeat (3) step();
      tile_active = 1'b0;
      seen        = 1'b0;
      repeat (6) begin
         step();
         if (grade_valid) seen = 1'b1;
      end
      chk("abort_no_pulse", int'(seen), 0);
      chk("abort_score", int'(score), exp_score);

      // Saturation: climb to FFFE then push past the top.
      do_reset();
      burst(21844, 8'd200, G_PERF);
      burst(2, 8'd212, G_GOOD);
      chk("sat_pre_score", int'(score), exp_score);
`ifndef TILE_HIT_JUDGE_COMBO_EN
      chk("sat_pre_fffe", int'(score), 32'hFFFE);
`endif
      burst(1, 8'd202, G_PERF);
      chk("sat_clamp", int'(score), 32'hFFFF);
      burst(1, 8'd200, G_PERF);
      chk("sat_hold", int'(score), 32'hFFFF);

      // Reset while armed with a press in flight.
      do_reset();
      run_tile(100, vecs[0]);
      repeat (2) step();
      count       = 8'd100;
      stop_at     = 8'd0;
      tile_active = 1'b1;
      repeat (3) step();
      btn_raw = 1'b1;
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_valid", int'(grade_valid), 0);
      chk("midrst_grade", int'(grade), int'(G_NONE));
      chk("midrst_score", int'(score), 0);
      chk("midrst_combo", int'(combo), 0);
      btn_raw = 1'b0;
      @(posedge clk);
      #1;
      step();
      reset     = 1'b0;
      exp_score = 0;
      exp_combo = 0;
      seen      = 1'b0;
      repeat (6) begin
         step();
         if (grade_valid) seen = 1'b1;
      end
      chk("midrst_no_grade", int'(seen), 0);
      count   = 8'd200;
      btn_raw = 1'b1;
      seen    = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         if (grade_valid) seen = 1'b1;
      end
      model_apply(G_PERF);
      chk("rearm_valid", int'(seen), 1);
      chk("rearm_grade", int'(grade), int'(G_PERF));
      chk("rearm_score", int'(score), exp_score);
      btn_raw     = 1'b0;
      tile_active = 1'b0;

      // Combo run: ten GOODs, one PERFECT, one MISS.
      do_reset();
      burst(10, 8'd212, G_GOOD);
      chk("combo10_score", int'(score), 10);
`ifdef TILE_HIT_JUDGE_COMBO_EN
      chk("combo10_combo", int'(combo), 10);
`else
      chk("combo10_combo", int'(combo), 0);
`endif
      burst(1, 8'd202, G_PERF);
`ifdef TILE_HIT_JUDGE_COMBO_EN
      chk("combo11_score", int'(score), 16);
      chk("combo11_combo", int'(combo), 11);
`else
      chk("combo11_score", int'(score), 13);
      chk("combo11_combo", int'(combo), 0);
`endif
      chk("combo11_model", int'(score), exp_score);
      run_tile(200, vecs[2]);
      chk("combo_miss_clear", int'(combo), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
